// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined IEEE-754 binary adder/subtractor with
// valid/ready handshakes, five rounding modes, flush-to-zero and special values.
// S1 unpack/classify/swap, S2 align/add/normalise, S3 round/pack.
// Optional build macro FP_ADD_SKID_EN: 2-entry output skid buffer after S3 with
// a registered in_ready; without it in_ready = !out_valid | out_ready.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         op,
  input  logic [2:0]   rounding_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic [2:0]   exception
);
  localparam int XW  = MAN_W + 4;          // hidden bit + fraction + G/R/S
  localparam int LZW = $clog2(XW + 1);
  localparam int EW  = EXP_W + LZW + 2;    // exponent workspace, MSB = sign
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;

  // ---------------- S1: unpack, classify, swap ----------------
  logic             a_s, b_s, a_zero, b_zero, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m;
  logic             sp, sp_inv;
  logic [W-1:0]     sp_res;

  assign a_s    = in1[W-1];
  assign b_s    = in2[W-1] ^ op;
  assign a_e    = in1[W-2:MAN_W];
  assign b_e    = in2[W-2:MAN_W];
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  // denormal inputs are flushed: their fraction is ignored
  assign a_m    = a_zero ? '0 : in1[MAN_W-1:0];
  assign b_m    = b_zero ? '0 : in2[MAN_W-1:0];
  assign a_nan  = (a_e == EMAX) && (a_m != '0);
  assign b_nan  = (b_e == EMAX) && (b_m != '0);
  assign a_snan = a_nan && !a_m[MAN_W-1];
  assign b_snan = b_nan && !b_m[MAN_W-1];
  assign a_inf  = (a_e == EMAX) && (a_m == '0);
  assign b_inf  = (b_e == EMAX) && (b_m == '0);
  assign swap   = {b_e, b_m} > {a_e, a_m};

  // NaN / infinity results bypass the arithmetic path
  always_comb begin
    sp     = a_nan | b_nan | a_inf | b_inf;
    sp_inv = a_snan | b_snan;
    sp_res = {b_s, EMAX, {MAN_W{1'b0}}};
    if (a_nan | b_nan) sp_res = QNAN;
    else if (a_inf & b_inf & (a_s != b_s)) begin
      sp_res = QNAN;
      sp_inv = 1'b1;
    end else if (a_inf) sp_res = {a_s, EMAX, {MAN_W{1'b0}}};
  end

  logic             s1_valid, s1_sp, s1_sp_inv, s1_sign, s1_sub;
  logic [W-1:0]     s1_sp_res;
  logic [EXP_W-1:0] s1_el, s1_es;
  logic [MAN_W:0]   s1_ml, s1_ms;
  logic [2:0]       s1_rm;

  // S1 register: larger magnitude operand goes to the "l" slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0; s1_sp <= 1'b0; s1_sp_inv <= 1'b0; s1_sp_res <= '0;
      s1_sign <= 1'b0; s1_sub <= 1'b0; s1_el <= '0; s1_es <= '0;
      s1_ml <= '0; s1_ms <= '0; s1_rm <= '0;
    end else if (en) begin
      s1_valid  <= in_valid & in_ready;
      s1_sp     <= sp;
      s1_sp_inv <= sp_inv;
      s1_sp_res <= sp_res;
      s1_sign   <= swap ? b_s : a_s;
      s1_sub    <= a_s ^ b_s;
      s1_el     <= swap ? b_e : a_e;
      s1_es     <= swap ? a_e : b_e;
      s1_ml     <= swap ? {~b_zero, b_m} : {~a_zero, a_m};
      s1_ms     <= swap ? {~a_zero, a_m} : {~b_zero, b_m};
      s1_rm     <= (rounding_mode > 3'd4) ? 3'd0 : rounding_mode;
    end
  end

  // ---------------- S2: align, add/sub, normalise ----------------
  int unsigned     shamt;
  logic [2*XW-1:0] sh_wide;
  logic [XW-1:0]   l_ext, s_al, norm;
  logic [XW:0]     sum;
  logic [LZW-1:0]  lz;
  logic [EW-1:0]   nexp;

  // right shift collects everything below the R bit into sticky
  always_comb begin
    shamt = 32'(s1_el) - 32'(s1_es);
    if (shamt > 32'(MAN_W + 3)) shamt = 32'(MAN_W + 3);
    l_ext   = {s1_ml, 3'b000};
    sh_wide = {s1_ms, 3'b000, {XW{1'b0}}} >> shamt;
    s_al    = {sh_wide[2*XW-1:XW+1], sh_wide[XW] | (|sh_wide[XW-1:0])};
    sum     = s1_sub ? ({1'b0, l_ext} - {1'b0, s_al}) : ({1'b0, l_ext} + {1'b0, s_al});
    lz = '0;
    for (int i = 0; i < XW; i++) if (sum[i]) lz = LZW'(XW - 1 - i);
    if (sum[XW]) begin
      norm = {sum[XW:2], sum[1] | sum[0]};
      nexp = EW'(s1_el) + EW'(1);
    end else begin
      norm = sum[XW-1:0] << lz;
      nexp = EW'(s1_el) - EW'(lz);
    end
  end

  logic             s2_valid, s2_sp, s2_sp_inv, s2_sign, s2_sub, s2_zero;
  logic [W-1:0]     s2_sp_res;
  logic [EW-1:0]    s2_exp;
  logic [XW-1:0]    s2_m;
  logic [2:0]       s2_rm;

  // S2 register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0; s2_sp <= 1'b0; s2_sp_inv <= 1'b0; s2_sp_res <= '0;
      s2_sign <= 1'b0; s2_sub <= 1'b0; s2_zero <= 1'b0; s2_exp <= '0;
      s2_m <= '0; s2_rm <= '0;
    end else if (en) begin
      s2_valid  <= s1_valid;
      s2_sp     <= s1_sp;
      s2_sp_inv <= s1_sp_inv;
      s2_sp_res <= s1_sp_res;
      s2_sign   <= s1_sign;
      s2_sub    <= s1_sub;
      s2_zero   <= (sum == '0);
      s2_exp    <= nexp;
      s2_m      <= norm;
      s2_rm     <= s1_rm;
    end
  end

  // ---------------- S3: round, range check, pack ----------------
  logic             g, st, up, to_inf, carry;
  logic [MAN_W+1:0] mr;
  logic [EW-1:0]    fexp;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res;
  logic [2:0]       exc;

  // rounding increment from LSB/G/sticky, sign and mode, then result select
  always_comb begin
    g  = s2_m[2];
    st = |s2_m[1:0];
    case (s2_rm)
      3'd1:    up = 1'b0;
      3'd2:    up = s2_sign & (g | st);
      3'd3:    up = ~s2_sign & (g | st);
      3'd4:    up = g;
      default: up = g & (st | s2_m[3]);
    endcase
    case (s2_rm)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = s2_sign;
      3'd3:    to_inf = ~s2_sign;
      default: to_inf = 1'b1;
    endcase
    mr    = {1'b0, s2_m[XW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    carry = mr[MAN_W+1];
    fexp  = s2_exp + {{(EW-1){1'b0}}, carry};
    frac  = carry ? mr[MAN_W:1] : mr[MAN_W-1:0];
    res   = {s2_sign, fexp[EXP_W-1:0], frac};
    exc   = {2'b00, g | st};
    if (s2_sp) begin
      res = s2_sp_res;
      exc = {s2_sp_inv, 2'b00};
    end else if (s2_zero) begin
      res = {s2_sub ? (s2_rm == 3'd2) : s2_sign, {(W-1){1'b0}}};
      exc = 3'b000;
    end else if (s2_exp[EW-1] || (s2_exp == '0)) begin
      res = {s2_sign, {(W-1){1'b0}}};
      exc = 3'b001;
    end else if (fexp >= EW'(EMAX)) begin
      exc = 3'b011;
      res = to_inf ? {s2_sign, EMAX, {MAN_W{1'b0}}} : {s2_sign, EMAX - 1'b1, {MAN_W{1'b1}}};
    end
  end

`ifdef FP_ADD_SKID_EN
  logic [1:0]   cnt, cnt_nxt;
  logic [W+2:0] e0, e1;
  logic         rdy_q, push, pop;

  assign en                = (cnt != 2'd2) | out_ready;
  assign in_ready          = rdy_q;
  assign out_valid         = (cnt != 2'd0);
  assign {out, exception}  = e0;
  assign pop               = out_valid & out_ready;
  assign push              = s2_valid & en;
  assign cnt_nxt           = cnt + {1'b0, push} - {1'b0, pop};

  // 2-entry skid FIFO; e0 is the head seen on the outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 2'd0; e0 <= '0; e1 <= '0; rdy_q <= 1'b1;
    end else begin
      cnt   <= cnt_nxt;
      rdy_q <= (cnt_nxt <= 2'd1);
      if (pop) begin
        e0 <= (push && cnt == 2'd1) ? {res, exc} : e1;
        if (push && cnt == 2'd2) e1 <= {res, exc};
      end else if (push) begin
        if (cnt == 2'd0) e0 <= {res, exc};
        else             e1 <= {res, exc};
      end
    end
  end
`else
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0; out <= '0; exception <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out       <= res;
        exception <= exc;
      end
    end
  end
`endif
endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe (single precision): directed vectors push
// expected results; a negedge monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_fp_add_pipe;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, op = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [W-1:0] in1 = '0, in2 = '0, out;
  logic [2:0] rounding_mode = '0, exception;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op), .rounding_mode(rounding_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .exception(exception)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  exc;
    bit          lat;
    int          iss;
    string       name;
  } exp_t;
  exp_t q[$];

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  // monitor: latency on first sight, stability while stalled, value on pop
  bit mon_en = 1'b1, head_seen = 1'b0, stall_prev = 1'b0;
  logic [31:0] prev_out;
  logic [2:0]  prev_exc;
  exp_t h;
  always @(negedge clk) begin
    if (!rst || !mon_en) begin
      head_seen  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_out", out, prev_out);
        chk("stall_exc", 32'(exception), 32'(prev_exc));
      end
      stall_prev = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_output", 32'(out_valid), 32'd0);
        else begin
          if (!head_seen && q[0].lat) chk({q[0].name, "/latency"}, 32'(cyc - q[0].iss), 32'd3);
          head_seen = 1'b1;
          if (out_ready) begin
            h = q.pop_front();
            chk({h.name, "/out"}, out, h.res);
            chk({h.name, "/exc"}, 32'(exception), 32'(h.exc));
            head_seen = 1'b0;
          end else begin
            stall_prev = 1'b1;
            prev_out   = out;
            prev_exc   = exception;
          end
        end
      end
    end
  end

  // called just after a rising edge; returns just after the accept edge
  task automatic send(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic o, input logic [2:0] rm,
                      input logic [31:0] er, input logic [2:0] ee, input bit lat);
    exp_t e;
    int n;
    in1 = a; in2 = b; op = o; rounding_mode = rm; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.res = er; e.exc = ee; e.lat = lat; e.iss = cyc; e.name = nm;
        q.push_back(e);
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 50) begin
        chk({nm, "/accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", out, 32'd0);
    chk("reset_exc", 32'(exception), 32'd0);
    rst = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // directed: name, a, b, op, rm, expected out, expected {inv,ovf,inx}, check latency
    send("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h40000000, 3'b000, 1'b1);
    send("x_minus_x_rne",  32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 32'h00000000, 3'b000, 1'b1);
    send("x_minus_x_rdn",  32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 32'h80000000, 3'b000, 1'b1);
    send("tie_rne",        32'h3F800000, 32'h33800000, 1'b0, 3'd0, 32'h3F800000, 3'b001, 1'b1);
    send("tie_rup",        32'h3F800000, 32'h33800000, 1'b0, 3'd3, 32'h3F800001, 3'b001, 1'b1);
    send("tie_rtz",        32'h3F800000, 32'h33800000, 1'b0, 3'd1, 32'h3F800000, 3'b001, 1'b1);
    send("tie_rmm",        32'h3F800000, 32'h33800000, 1'b0, 3'd4, 32'h3F800001, 3'b001, 1'b1);
    send("tie_rm5_as_rne", 32'h3F800000, 32'h33800000, 1'b0, 3'd5, 32'h3F800000, 3'b001, 1'b1);
    send("ovf_rne",        32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 3'b011, 1'b1);
    send("ovf_rtz",        32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 32'h7F7FFFFF, 3'b011, 1'b1);
    send("neg_ovf_rdn",    32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd2, 32'hFF800000, 3'b011, 1'b1);
    send("neg_ovf_rup",    32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd3, 32'hFF7FFFFF, 3'b011, 1'b1);
    send("inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 32'h7FC00000, 3'b100, 1'b1);
    send("snan_plus_one",  32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 3'b100, 1'b1);
    send("qnan_plus_one",  32'h7FC00001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 3'b000, 1'b1);
    send("inf_plus_one",   32'h7F800000, 32'h3F800000, 1'b0, 3'd0, 32'h7F800000, 3'b000, 1'b1);
    send("denorm_ftz",     32'h00400000, 32'h80000000, 1'b0, 3'd0, 32'h00000000, 3'b000, 1'b1);
    send("neg0_plus_neg0", 32'h80000000, 32'h80000000, 1'b0, 3'd0, 32'h80000000, 3'b000, 1'b1);
    send("underflow",      32'h00800000, 32'h00800001, 1'b1, 3'd0, 32'h80000000, 3'b001, 1'b1);
    drain();

    // back-to-back stream with a 5-cycle downstream stall in the middle
    fork
      begin
        send("s0_1p1",    32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h40000000, 3'b000, 1'b0);
        send("s1_2p1",    32'h40000000, 32'h3F800000, 1'b0, 3'd0, 32'h40400000, 3'b000, 1'b0);
        send("s2_1m0p5",  32'h3F800000, 32'h3F000000, 1'b1, 3'd0, 32'h3F000000, 3'b000, 1'b0);
        send("s3_1p5p2p5",32'h3FC00000, 32'h40200000, 1'b0, 3'd0, 32'h40800000, 3'b000, 1'b0);
        send("s4_m1p2",   32'hBF800000, 32'h40000000, 1'b0, 3'd0, 32'h3F800000, 3'b000, 1'b0);
        send("s5_3m1",    32'h40400000, 32'h3F800000, 1'b1, 3'd0, 32'h40000000, 3'b000, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // burst interrupted by an asynchronous reset: in-flight work is dropped
    mon_en = 1'b0;
    out_ready = 1'b0;
    in1 = 32'h3F800000; in2 = 32'h3F800000; op = 1'b0; rounding_mode = 3'd0;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("burst_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out", out, 32'd0);
    chk("async_rst_exc", 32'(exception), 32'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("no_output_after_rst", 32'(n), 32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    send("post_rst_1p1", 32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h40000000, 3'b000, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor with valid/ready handshakes on input and output. It replaces the combinational single-precision adder in the FPU datapath and adds the following:
- Generic exponent and mantissa widths.
- An add/sub opcode.
- Five rounding modes.
- Special-value handling.
- Backpressure.

It sits between the FPU operand dispatch and the result writeback arbiter.

Parameters:
EXP_W, 8, exponent field width (≥4)
MAN_W, 23, stored mantissa width, hidden bit excluded (≥4)
W, EXP_W+MAN_W+1, total operand width (derived, not overridable)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operands this cycle
in1  input  W  operand A {sign, exp, man}
in2  input  W  operand B
op  input  1  0 = A+B, 1 = A−B (sign of B inverted before alignment)
rounding_mode  input  3  000 RNE, 001 RTZ, 010 RDN (−inf), 011 RUP (+inf), 100 RMM; 101–111 treated as RNE
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out  output  W  result
exception  output  3  {invalid, overflow, inexact}

Behaviour:
- Reset (rst low, asynchronous): all stage valid bits clear; out_valid=0, out=0, exception=0. in_ready=1 once reset deasserts. Any in-flight operations are discarded with no output.
- Pipeline: 3 stages. Latency is exactly 3 cycles from the accept edge (in_valid & in_ready) to out_valid, absent stalls. Throughput is 1 per cycle.
  - S1: unpack, special-case detect, swap so the larger magnitude is first (compare exp, then mantissa), compute effective op.
  - S2: align the smaller operand with right shift, saturating at MAN_W+3. Shifted-out bits form guard, round and sticky (G/R/S). Then add or subtract, and normalise (1-bit right on carry-out; leading-zero count and left shift on subtract).
  - S3: round, handle exponent overflow/underflow, pack, register outputs.
- Handshake: global advance en = !out_valid | out_ready.
  - in_ready = en (combinational) in the base build.
  - When en=0, all stages hold their contents.
  - out, exception and out_valid are stable while out_valid & !out_ready.
- Inputs with exp=0 are treated as signed zero (flush-to-zero). Results below the minimum normal flush to signed zero with inexact=1.
- Rounding: increment decision comes from the result LSB, G, R, S, the result sign and the mode. A mantissa carry-out after rounding increments the exponent.
- Overflow (biased exp reaches all-ones): overflow=1, inexact=1.
  - Result is ±inf for RNE/RMM.
  - Result is ±inf or ±max-finite for the directed modes, per IEEE-754.
- Exact zero from x−x: result +0, except −0 when the mode is RDN. A zero plus a zero of the same sign keeps that sign.
- NaN inputs: any NaN input gives canonical qNaN (sign 0, exp all-ones, man MSB 1, rest 0). invalid=1 only when an input is a signalling NaN.
- Infinities:
  - inf−inf (effective): canonical qNaN, invalid=1.
  - inf ± finite: that inf, exception 0.
- inexact=1 whenever G|R|S is nonzero after normalisation, or on overflow/underflow flush.

Optional Feature:
FP_ADD_SKID_EN
- Defined: a 2-entry output skid buffer follows S3, and in_ready is driven purely from registers (1 iff the buffer has at most one entry and no stall is pending). Latency is unchanged at 3 when out_ready=1. With out_ready low, up to 2 extra results are absorbed without loss.
- Undefined: no buffer; in_ready = !out_valid | out_ready (combinational path from out_ready).

Test Plan:
- RNE, op=0, 0x3F800000 + 0x3F800000 -> out 0x40000000, exception 000, out_valid exactly 3 cycles after accept.
- op=1, 0x3F800000 − 0x3F800000 -> RNE gives 0x00000000; RDN gives 0x80000000; exception 000 in both.
- 0x3F800000 + 0x33800000 -> RNE 0x3F800000, exception 001; RUP 0x3F800001, exception 001; RTZ 0x3F800000.
- 0x7F7FFFFF + 0x7F7FFFFF -> RNE 0x7F800000, exception 011; RTZ 0x7F7FFFFF, exception 011.
- 0x7F800000 − 0x7F800000 (op=1) -> 0x7FC00000, exception 100. Signalling NaN 0x7F800001 + 1.0 -> 0x7FC00000, exception 100.
- Back-to-back stream of 6 ops with out_ready held low for 5 cycles mid-stream, then rst pulsed low during a later burst:
  - All pre-reset results emerge in order with no loss or duplication, and outputs stay stable while stalled.
  - On reset, out_valid drops asynchronously and out/exception read 0.
